// File: rtl/bcd_mod_counter.sv
// N-digit packed-BCD modulo counter: up/down, load, enable, cascadable terminal count.
// Build with BCD_CNT_LOAD_CHECK_EN to reject illegal loads and expose the ERR flag.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                CP,
  input  logic                CR,
  input  logic                EN,
  input  logic                UP,
  input  logic                LD,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                TC
`ifdef BCD_CNT_LOAD_CHECK_EN
  ,
  output logic                ERR
`endif
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  // With every digit <= 9 the packed compare orders exactly like the decimal value.
  function automatic logic is_legal(input logic [W-1:0] v);
    logic ok;
    ok = (v <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] cnt_q, cnt_d;
  logic         legal_q;
`ifdef BCD_CNT_LOAD_CHECK_EN
  logic         err_q, err_d;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    legal_q = is_legal(cnt_q);
`ifdef BCD_CNT_LOAD_CHECK_EN
    err_d   = 1'b0;
`endif
    if (LD) begin
`ifdef BCD_CNT_LOAD_CHECK_EN
      if (is_legal(D)) cnt_d = D;
      else             err_d = 1'b1;
`else
      cnt_d = D;
`endif
    end else if (EN) begin
      // An illegal value (only reachable through an unchecked load) recovers in one count.
      if (!legal_q)                cnt_d = UP ? '0 : MAX_BCD;
      else if (UP)                 cnt_d = (cnt_q == MAX_BCD) ? '0 : bcd_inc(cnt_q);
      else                         cnt_d = (cnt_q == '0) ? MAX_BCD : bcd_dec(cnt_q);
    end
  end

  always_ff @(negedge CP or posedge CR) begin
    if (CR) cnt_q <= '0;
    else    cnt_q <= cnt_d;
  end

`ifdef BCD_CNT_LOAD_CHECK_EN
  always_ff @(negedge CP or posedge CR) begin
    if (CR) err_q <= 1'b0;
    else    err_q <= err_d;
  end

  assign ERR = err_q;
`endif

  assign Q  = cnt_q;
  assign TC = EN & legal_q & ((UP & (cnt_q == MAX_BCD)) | (~UP & (cnt_q == '0)));

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: mod-60 seconds cascaded into mod-60 minutes, plus a mod-24 down-counter.
module tb_bcd_mod_counter;

  logic       CP = 1'b1;
  logic       CR = 1'b1;
  logic       en_s = 0, up_s = 1, ld_s = 0;
  logic       up_m = 1, ld_m = 0;
  logic       en_h = 0, up_h = 1, ld_h = 0;
  logic [7:0] d_s = '0, d_m = '0, d_h = '0;
  logic [7:0] q_s, q_m, q_h;
  logic       tc_s, tc_m, tc_h;
`ifdef BCD_CNT_LOAD_CHECK_EN
  logic       err_s, err_m, err_h;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CP = ~CP;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_sec (
    .CP(CP), .CR(CR), .EN(en_s), .UP(up_s), .LD(ld_s), .D(d_s), .Q(q_s), .TC(tc_s)
`ifdef BCD_CNT_LOAD_CHECK_EN
    , .ERR(err_s)
`endif
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_min (
    .CP(CP), .CR(CR), .EN(tc_s), .UP(up_m), .LD(ld_m), .D(d_m), .Q(q_m), .TC(tc_m)
`ifdef BCD_CNT_LOAD_CHECK_EN
    , .ERR(err_m)
`endif
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
    .CP(CP), .CR(CR), .EN(en_h), .UP(up_h), .LD(ld_h), .D(d_h), .Q(q_h), .TC(tc_h)
`ifdef BCD_CNT_LOAD_CHECK_EN
    , .ERR(err_h)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CP);
    #1;
  endtask

  int         exp_v;
  logic [7:0] exp_bcd;

  initial begin
    #3;
    chk("rst_q_s", q_s, 8'h00);
    chk("rst_q_h", q_h, 8'h00);
    chk("rst_tc_s", tc_s, 1'b0);
    tick();
    CR = 1'b0;

    // load 0x37, then reset between edges
    ld_s = 1; d_s = 8'h37;
    tick();
    ld_s = 0;
    chk("load_37", q_s, 8'h37);
    CR = 1'b1;
    #1;
    chk("mid_rst_q", q_s, 8'h00);
    #2;
    CR = 1'b0;
    en_s = 1; up_s = 1;
    tick();
    chk("post_rst_cnt", q_s, 8'h01);

    // full mod-60 up sweep from 0x01 back to 0x00
    exp_v = 1;
    repeat (59) begin
      chk("up60_tc", tc_s, (exp_v == 59));
      tick();
      exp_v   = (exp_v + 1) % 60;
      exp_bcd = {4'(exp_v / 10), 4'(exp_v % 10)};
      chk("up60_q", q_s, exp_bcd);
      if (exp_v == 10) chk("up60_roll_09_10", q_s, 8'h10);
    end
    chk("up60_wrap0", q_s, 8'h00);
    chk("min_carry", q_m, 8'h01);
    en_s = 0;

    // mod-24 down-counting
    en_h = 1; up_h = 0;
    #1;
    chk("dn24_tc_at0", tc_h, 1'b1);
    en_h = 0;
    #1;
    chk("dn24_tc_en0", tc_h, 1'b0);
    en_h = 1;
    tick();
    chk("dn24_wrap", q_h, 8'h23);
    chk("dn24_tc_23", tc_h, 1'b0);
    tick();
    chk("dn24_22", q_h, 8'h22);
    en_h = 0; ld_h = 1; d_h = 8'h10;
    tick();
    ld_h = 0; en_h = 1;
    tick();
    chk("dn24_roll_10_09", q_h, 8'h09);
    en_h = 0;

    // load beats enable, then hold
    ld_s = 1; d_s = 8'h12;
    tick();
    chk("load_12", q_s, 8'h12);
    en_s = 1; up_s = 1; d_s = 8'h45;
    tick();
    chk("load_pri", q_s, 8'h45);
    ld_s = 0; en_s = 0;
    repeat (3) tick();
    chk("hold_45", q_s, 8'h45);

    // cascade 59:59 -> 00:00
    ld_s = 1; d_s = 8'h59; ld_m = 1; d_m = 8'h59; up_m = 1;
    tick();
    ld_s = 0; ld_m = 0; en_s = 1; up_s = 1;
    #1;
    chk("casc_tc_s", tc_s, 1'b1);
    chk("casc_tc_m", tc_m, 1'b1);
    tick();
    chk("casc_sec", q_s, 8'h00);
    chk("casc_min", q_m, 8'h00);
    chk("casc_tc_m_after", tc_m, 1'b0);
    en_s = 0;

    // illegal load 0x7A
    ld_s = 1; d_s = 8'h7A;
    tick();
    ld_s = 0;
`ifdef BCD_CNT_LOAD_CHECK_EN
    chk("ill_rejected", q_s, 8'h00);
    chk("ill_err_set", err_s, 1'b1);
    tick();
    chk("ill_err_clr", err_s, 1'b0);
    chk("ill_hold", q_s, 8'h00);
`else
    chk("ill_loaded", q_s, 8'h7A);
    en_s = 1; up_s = 1;
    #1;
    chk("ill_tc_up", tc_s, 1'b0);
    tick();
    chk("ill_rec_up", q_s, 8'h00);
    en_s = 0; ld_s = 1;
    tick();
    ld_s = 0; en_s = 1; up_s = 0;
    #1;
    chk("ill_tc_dn", tc_s, 1'b0);
    tick();
    chk("ill_rec_dn", q_s, 8'h59);
    en_s = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
